// File: rtl/nn_wx_mem_responder_pkg.sv
// Shared widths, depths, host-FSM states and helpers for the weight/activation memory responder.
package nn_wx_mem_responder_pkg;

    localparam int W_ADDR_LEN = 20;
    localparam int X_ADDR_LEN = 10;
    localparam int SEL_LEN    = 2;
    localparam int W_DEPTH    = 16;
    localparam int X_DEPTH    = 8;
    localparam int CYC_LEN    = 24;
    localparam int LD_CNT_LEN = W_ADDR_LEN + SEL_LEN + 1;

    localparam logic [SEL_LEN-1:0] SEL_L1 = SEL_LEN'(0);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_READY,
        ST_RUN,
        ST_DONE
    } state_e;

    function automatic logic [CYC_LEN-1:0] sat_inc(input logic [CYC_LEN-1:0] v);
        return (&v) ? v : v + CYC_LEN'(1);
    endfunction

endpackage

// File: rtl/nn_wx_mem_responder_bit_bank.sv
// Four 1-bit-wide banks sharing one synchronous write port and two combinational read ports.
module nn_bit_bank #(
    parameter int ADDR_LEN = 20,
    parameter int DEPTH    = 16,
    parameter int SEL_LEN  = 2
) (
    input  logic                clk,
    input  logic                we,
    input  logic [SEL_LEN-1:0]  wsel,
    input  logic [ADDR_LEN-1:0] waddr,
    input  logic                wdata,
    output logic                oob,
    input  logic [SEL_LEN-1:0]  rsel_a,
    input  logic [ADDR_LEN-1:0] raddr_a,
    output logic                rdata_a,
    input  logic [SEL_LEN-1:0]  rsel_b,
    input  logic [ADDR_LEN-1:0] raddr_b,
    output logic                rdata_b
);

    localparam int IDX_LEN = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int N_BANKS = 1 << SEL_LEN;

    logic [DEPTH-1:0] mem [N_BANKS];

    function automatic logic in_range(input logic [ADDR_LEN-1:0] a);
        return a < ADDR_LEN'(DEPTH);
    endfunction

    // Out-of-range writes are dropped here; the caller decides what to do with the flag.
    assign oob = we && !in_range(waddr);

    // NOTE: storage has no reset branch; clearing a memory costs a mux per bit and contents are
    // always loaded by the host before use, so only the control state is reset.
    always_ff @(posedge clk) begin
        if (we && in_range(waddr)) begin
            mem[wsel][waddr[IDX_LEN-1:0]] <= wdata;
        end
    end

    assign rdata_a = in_range(raddr_a) ? mem[rsel_a][raddr_a[IDX_LEN-1:0]] : 1'b0;
    assign rdata_b = in_range(raddr_b) ? mem[rsel_b][raddr_b[IDX_LEN-1:0]] : 1'b0;

endmodule

// File: rtl/nn_wx_mem_responder.sv
// Memory-side responder for compute_module: weight/activation banks, host load FSM and run control.
module nn_wx_mem_responder
    import nn_wx_mem_responder_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    output logic                  en,
    input  logic                  compute_finish,
    input  logic                  wx_write,
    input  logic [W_ADDR_LEN-1:0] w_addr,
    input  logic [SEL_LEN-1:0]    w_sel,
    input  logic                  w_wq,
    output logic                  w_data,
    input  logic [X_ADDR_LEN-1:0] x_addr,
    input  logic [SEL_LEN-1:0]    x_sel,
    input  logic                  x_wq,
    output logic                  x_data,
    input  logic                  load_req,
    input  logic                  start,
    input  logic                  ld_valid,
    output logic                  ld_ready,
    input  logic                  ld_is_x,
    input  logic [SEL_LEN-1:0]    ld_sel,
    input  logic [W_ADDR_LEN-1:0] ld_addr,
    input  logic                  ld_data,
    input  logic                  ld_last,
    input  logic [SEL_LEN-1:0]    rd_sel,
    input  logic [X_ADDR_LEN-1:0] rd_addr,
    output logic                  rd_data,
    output logic                  done,
    output logic [LD_CNT_LEN-1:0] ld_count,
    output logic [CYC_LEN-1:0]    run_cycles,
    output logic                  oob_err
);

    state_e state;
    logic   run_first;

    logic                  w_we, w_wdata, w_oob;
    logic [SEL_LEN-1:0]    w_wsel;
    logic [W_ADDR_LEN-1:0] w_waddr;
    logic                  x_we, x_wdata, x_oob;
    logic [SEL_LEN-1:0]    x_wsel;
    logic [X_ADDR_LEN-1:0] x_waddr;
    logic                  w_rd_unused;

    // Host owns the write ports during LOAD, compute_module during RUN; elsewhere writes are dropped.
    // NOTE: every output gets a default before the branches so no path leaves one unassigned,
    // which would otherwise infer a latch.
    always_comb begin
        w_we    = 1'b0;
        w_wsel  = w_sel;
        w_waddr = w_addr;
        w_wdata = wx_write;
        x_we    = 1'b0;
        x_wsel  = x_sel;
        x_waddr = x_addr;
        x_wdata = wx_write;
        if (state == ST_LOAD) begin
            w_we    = ld_valid && !ld_is_x;
            w_wsel  = ld_sel;
            w_waddr = ld_addr;
            w_wdata = ld_data;
            x_we    = ld_valid && ld_is_x;
            x_wsel  = ld_sel;
            x_waddr = ld_addr[X_ADDR_LEN-1:0];
            x_wdata = ld_data;
        end else if (state == ST_RUN) begin
            w_we = w_wq;
            x_we = x_wq;
        end
    end

    nn_bit_bank #(
        .ADDR_LEN (W_ADDR_LEN),
        .DEPTH    (W_DEPTH),
        .SEL_LEN  (SEL_LEN)
    ) u_wbank (
        .clk     (clk),
        .we      (w_we),
        .wsel    (w_wsel),
        .waddr   (w_waddr),
        .wdata   (w_wdata),
        .oob     (w_oob),
        .rsel_a  (w_sel),
        .raddr_a (w_addr),
        .rdata_a (w_data),
        .rsel_b  (SEL_L1),
        .raddr_b ('0),
        .rdata_b (w_rd_unused)
    );

    nn_bit_bank #(
        .ADDR_LEN (X_ADDR_LEN),
        .DEPTH    (X_DEPTH),
        .SEL_LEN  (SEL_LEN)
    ) u_xbank (
        .clk     (clk),
        .we      (x_we),
        .wsel    (x_wsel),
        .waddr   (x_waddr),
        .wdata   (x_wdata),
        .oob     (x_oob),
        .rsel_a  (x_sel),
        .raddr_a (x_addr),
        .rdata_a (x_data),
        .rsel_b  (rd_sel),
        .raddr_b (rd_addr),
        .rdata_b (rd_data)
    );

    // NOTE: all state and registered outputs use non-blocking assignments so every branch sees
    // the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            en         <= 1'b0;
            ld_ready   <= 1'b0;
            done       <= 1'b0;
            ld_count   <= '0;
            run_cycles <= '0;
            oob_err    <= 1'b0;
            run_first  <= 1'b0;
        end else begin
            if (w_oob || x_oob) begin
                oob_err <= 1'b1;
            end
            case (state)
                ST_IDLE: begin
                    if (load_req) begin
                        state    <= ST_LOAD;
                        ld_ready <= 1'b1;
                        ld_count <= '0;
                        oob_err  <= 1'b0;
                    end
                end
                ST_LOAD: begin
                    if (ld_valid) begin
                        ld_count <= ld_count + LD_CNT_LEN'(1);
                        if (ld_last) begin
                            state    <= ST_READY;
                            ld_ready <= 1'b0;
                        end
                    end
                end
                ST_READY, ST_DONE: begin
                    // load_req outranks start when both arrive together.
                    if (load_req) begin
                        state    <= ST_LOAD;
                        ld_ready <= 1'b1;
                        done     <= 1'b0;
                        ld_count <= '0;
                        oob_err  <= 1'b0;
                    end else if (start) begin
                        state      <= ST_RUN;
                        en         <= 1'b1;
                        done       <= 1'b0;
                        run_cycles <= '0;
                        run_first  <= 1'b1;
                    end
                end
                ST_RUN: begin
                    run_cycles <= sat_inc(run_cycles);
                    run_first  <= 1'b0;
                    // A finish seen in the first RUN cycle is stale from the previous run.
                    if (compute_finish && !run_first) begin
                        state <= ST_DONE;
                        en    <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                default: begin
                    state    <= ST_IDLE;
                    en       <= 1'b0;
                    ld_ready <= 1'b0;
                    done     <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_nn_wx_mem_responder.sv
// Self-checking bench: behavioural model of banks and host FSM compared against the DUT every cycle.
module tb_nn_wx_mem_responder;
    import nn_wx_mem_responder_pkg::*;

    logic                  clk = 1'b0;
    logic                  rst_n;
    logic                  en, compute_finish, wx_write;
    logic [W_ADDR_LEN-1:0] w_addr;
    logic [SEL_LEN-1:0]    w_sel;
    logic                  w_wq, w_data;
    logic [X_ADDR_LEN-1:0] x_addr;
    logic [SEL_LEN-1:0]    x_sel;
    logic                  x_wq, x_data;
    logic                  load_req, start, ld_valid, ld_ready, ld_is_x;
    logic [SEL_LEN-1:0]    ld_sel;
    logic [W_ADDR_LEN-1:0] ld_addr;
    logic                  ld_data, ld_last;
    logic [SEL_LEN-1:0]    rd_sel;
    logic [X_ADDR_LEN-1:0] rd_addr;
    logic                  rd_data, done, oob_err;
    logic [LD_CNT_LEN-1:0] ld_count;
    logic [CYC_LEN-1:0]    run_cycles;

    always #5 clk = ~clk;

    nn_wx_mem_responder dut (
        .clk(clk), .rst_n(rst_n), .en(en), .compute_finish(compute_finish), .wx_write(wx_write),
        .w_addr(w_addr), .w_sel(w_sel), .w_wq(w_wq), .w_data(w_data),
        .x_addr(x_addr), .x_sel(x_sel), .x_wq(x_wq), .x_data(x_data),
        .load_req(load_req), .start(start), .ld_valid(ld_valid), .ld_ready(ld_ready),
        .ld_is_x(ld_is_x), .ld_sel(ld_sel), .ld_addr(ld_addr), .ld_data(ld_data), .ld_last(ld_last),
        .rd_sel(rd_sel), .rd_addr(rd_addr), .rd_data(rd_data), .done(done),
        .ld_count(ld_count), .run_cycles(run_cycles), .oob_err(oob_err)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h at %0t", name, got, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef enum {M_IDLE, M_LOAD, M_READY, M_RUN, M_DONE} mode_t;
    mode_t m_mode;
    bit    wmem [4][16];
    bit    wkn  [4][16];
    bit    xmem [4][8];
    bit    xkn  [4][8];
    int    m_cnt, m_cycles;
    bit    m_oob;
    bit    cmp_on = 1'b0;

    function automatic void m_write(input bit is_x, input int sel, input longint addr, input bit d);
        if (is_x) begin
            if (addr < 8) begin xmem[sel][addr] = d; xkn[sel][addr] = 1'b1; end
            else m_oob = 1'b1;
        end else begin
            if (addr < 16) begin wmem[sel][addr] = d; wkn[sel][addr] = 1'b1; end
            else m_oob = 1'b1;
        end
    endfunction

    function automatic void m_enter_load();
        m_mode = M_LOAD;
        m_cnt  = 0;
        m_oob  = 1'b0;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_mode = M_IDLE; m_cnt = 0; m_cycles = 0; m_oob = 1'b0;
        end else begin
            case (m_mode)
                M_IDLE: if (load_req) m_enter_load();
                M_LOAD: if (ld_valid) begin
                    m_write(ld_is_x, int'(ld_sel),
                            ld_is_x ? longint'(ld_addr % 1024) : longint'(ld_addr), ld_data);
                    m_cnt++;
                    if (ld_last) m_mode = M_READY;
                end
                M_READY, M_DONE: begin
                    if (load_req) m_enter_load();
                    else if (start) begin m_mode = M_RUN; m_cycles = 0; end
                end
                M_RUN: begin
                    if (x_wq) m_write(1'b1, int'(x_sel), longint'(x_addr), wx_write);
                    if (w_wq) m_write(1'b0, int'(w_sel), longint'(w_addr), wx_write);
                    if (compute_finish && m_cycles > 0) m_mode = M_DONE;
                    if (m_cycles < (1 << CYC_LEN) - 1) m_cycles++;
                end
                default: m_mode = M_IDLE;
            endcase
        end
    end

    // Single compare process, away from the active edge.
    always @(negedge clk) begin
        if (cmp_on) begin
            check("en", en, m_mode == M_RUN);
            check("ld_ready", ld_ready, m_mode == M_LOAD);
            check("done", done, m_mode == M_DONE);
            check("ld_count", ld_count, m_cnt);
            check("run_cycles", run_cycles, m_cycles);
            check("oob_err", oob_err, m_oob);
            if (w_addr >= 16) check("w_data_oor", w_data, 0);
            else if (wkn[w_sel][w_addr]) check("w_data", w_data, wmem[w_sel][w_addr]);
            if (x_addr >= 8) check("x_data_oor", x_data, 0);
            else if (xkn[x_sel][x_addr]) check("x_data", x_data, xmem[x_sel][x_addr]);
            if (rd_addr >= 8) check("rd_data_oor", rd_data, 0);
            else if (xkn[rd_sel][rd_addr]) check("rd_data", rd_data, xmem[rd_sel][rd_addr]);
        end
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        compute_finish = 0; wx_write = 0; w_addr = '0; w_sel = '0; w_wq = 0;
        x_addr = '0; x_sel = '0; x_wq = 0; load_req = 0; start = 0; ld_valid = 0;
        ld_is_x = 0; ld_sel = '0; ld_addr = '0; ld_data = 0; ld_last = 0; rd_sel = '0; rd_addr = '0;
    endtask

    task automatic beat(input bit is_x, input int sel, input int addr, input bit d, input bit last);
        ld_valid = 1; ld_is_x = is_x; ld_sel = SEL_LEN'(sel); ld_addr = W_ADDR_LEN'(addr);
        ld_data = d; ld_last = last;
        step();
        ld_valid = 0; ld_last = 0;
    endtask

    initial begin
        bit wb [6];
        wb = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        idle_inputs();
        rst_n = 1'b0;
        repeat (2) step();
        check("reset_en", en, 0);
        check("reset_ld_ready", ld_ready, 0);
        check("reset_ld_count", ld_count, 0);
        check("reset_oob", oob_err, 0);
        rst_n = 1'b1;
        cmp_on = 1'b1;

        // Fill every implemented bit with zero so later reads are all known.
        load_req = 1; step(); load_req = 0;
        check("load_entry_ready", ld_ready, 1);
        for (int s = 0; s < 4; s++)
            for (int a = 0; a < 16; a++) beat(1'b0, s, a, 1'b0, 1'b0);
        for (int s = 0; s < 4; s++)
            for (int a = 0; a < 8; a++) beat(1'b1, s, a, 1'b0, (s == 3) && (a == 7));
        check("fill_count", ld_count, 96);

        // Directed load: weights 101100 at bank0 addr0..5, x bits 1,0 at bank0, last on beat 8.
        load_req = 1; step(); load_req = 0;
        for (int a = 0; a < 6; a++) beat(1'b0, 0, a, wb[a], 1'b0);
        beat(1'b1, 0, 0, 1'b1, 1'b0);
        beat(1'b1, 0, 1, 1'b0, 1'b1);
        check("dir_count", ld_count, 8);
        check("dir_ready_fell", ld_ready, 0);
        w_sel = 0; w_addr = 2; #1;
        check("dir_w2", w_data, 1);
        w_addr = 4; #1;
        check("dir_w4", w_data, 0);

        // Run: compute writes x[1][3]; old value visible until the edge.
        start = 1; step(); start = 0;
        check("run_en", en, 1);
        x_wq = 1; x_sel = 1; x_addr = 3; wx_write = 1; rd_sel = 1; rd_addr = 3; #1;
        check("rd_before_edge", rd_data, 0);
        step(); x_wq = 0; wx_write = 0;
        check("rd_after_edge", rd_data, 1);
        repeat (38) step();
        compute_finish = 1; step(); compute_finish = 0;
        check("fin_done", done, 1);
        check("fin_en", en, 0);
        check("fin_cycles", run_cycles, 40);

        // Rerun keeps banks; out-of-range x write flags oob and changes nothing.
        start = 1; step(); start = 0;
        for (int a = 0; a < 6; a++) begin
            w_addr = W_ADDR_LEN'(a); #1;
            check("rerun_w", w_data, wb[a]);
        end
        x_wq = 1; x_sel = 0; x_addr = 8; wx_write = 1; step(); x_wq = 0; wx_write = 0;
        check("oob_set", oob_err, 1);
        x_addr = 0; #1;
        check("oob_x0_intact", x_data, 1);
        compute_finish = 1; step(); compute_finish = 0;
        check("done2", done, 1);

        // load_req and start together in DONE pick LOAD; entering LOAD clears oob_err.
        load_req = 1; start = 1; step(); load_req = 0; start = 0;
        check("both_ld_ready", ld_ready, 1);
        check("both_en", en, 0);
        check("both_oob_clr", oob_err, 0);
        beat(1'b1, 2, 5, 1'b1, 1'b1);
        x_wq = 1; x_sel = 2; x_addr = 5; wx_write = 0; rd_sel = 2; rd_addr = 5; step(); x_wq = 0;
        check("ready_xwq_ignored", rd_data, 1);

        // A finish held through RUN entry is ignored in the first RUN cycle.
        compute_finish = 1; start = 1; step(); start = 0;
        step();
        check("first_cycle_en", en, 1);
        step(); compute_finish = 0;
        check("first_cycle_done", done, 1);
        check("first_cycle_cycles", run_cycles, 2);

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            load_req = ($urandom_range(0, 19) == 0);
            start = ($urandom_range(0, 9) == 0);
            compute_finish = ($urandom_range(0, 15) == 0);
            ld_valid = 1'($urandom_range(0, 1));
            ld_is_x = 1'($urandom_range(0, 1));
            ld_sel = SEL_LEN'($urandom_range(0, 3));
            ld_addr = ld_is_x ? W_ADDR_LEN'($urandom_range(0, 9)) : W_ADDR_LEN'($urandom_range(0, 18));
            if ($urandom_range(0, 40) == 0) ld_addr = W_ADDR_LEN'($urandom_range(1024, 1031));
            ld_data = 1'($urandom_range(0, 1));
            ld_last = ($urandom_range(0, 11) == 0);
            w_wq = 1'($urandom_range(0, 1));
            x_wq = 1'($urandom_range(0, 1));
            w_sel = SEL_LEN'($urandom_range(0, 3));
            x_sel = SEL_LEN'($urandom_range(0, 3));
            w_addr = W_ADDR_LEN'($urandom_range(0, 18));
            x_addr = X_ADDR_LEN'($urandom_range(0, 9));
            wx_write = 1'($urandom_range(0, 1));
            rd_sel = SEL_LEN'($urandom_range(0, 3));
            rd_addr = X_ADDR_LEN'($urandom_range(0, 9));
            step();
        end

        // Async reset between edges in RUN: en drops at once, bank contents survive.
        idle_inputs();
        rst_n = 0; step(); rst_n = 1;
        load_req = 1; step(); load_req = 0;
        beat(1'b0, 3, 15, 1'b1, 1'b1);
        start = 1; step(); start = 0;
        check("pre_rst_en", en, 1);
        repeat (3) step();
        #2 rst_n = 0; #1;
        check("async_en", en, 0);
        check("async_done", done, 0);
        check("async_ld_ready", ld_ready, 0);
        check("async_cycles", run_cycles, 0);
        w_sel = 3; w_addr = 15; #1;
        check("async_w_kept", w_data, 1);
        step();
        rst_n = 1;
        repeat (3) step();
        cmp_on = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
